// File: rtl/wb_bfm_pkg.sv
// Shared constants and types for the Wishbone slave front-end.
package wb_bfm_pkg;

    // Cycle type identifiers carried on wb_cti_i
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    // Burst type extensions carried on wb_bte_i
    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    // Kind of bus cycle latched on its first beat
    localparam logic CLASSIC_CYCLE = 1'b0;
    localparam logic BURST_CYCLE   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // A beat is the last one of its cycle for classic cycles or an end-of-burst tag
    function automatic logic is_last(input logic burst, input logic [2:0] cti);
        return (burst == CLASSIC_CYCLE) || (cti == CTI_END);
    endfunction

endpackage

// File: rtl/wb_slave_bfm_next_adr.sv
// Combinational beat address generator for constant, linear and wrapping bursts.
module wb_next_adr
    import wb_bfm_pkg::*;
#(
    parameter int aw = 32,
    parameter int dw = 32
) (
    input  logic [aw-1:0] adr,
    input  logic [2:0]    cti,
    input  logic [1:0]    bte,
    output logic [aw-1:0] next_adr
);

    localparam int BYTES = dw / 8;
    localparam logic [aw-1:0] STEP   = aw'(BYTES);
    localparam logic [aw-1:0] MASK4  = aw'(4 * BYTES - 1);
    localparam logic [aw-1:0] MASK8  = aw'(8 * BYTES - 1);
    localparam logic [aw-1:0] MASK16 = aw'(16 * BYTES - 1);

    logic [aw-1:0] inc;
    logic [aw-1:0] wrap_mask;

    // Bits inside wrap_mask take the incremented value, bits above it stay put
    always_comb begin
        inc = adr + STEP;
        case (bte)
            BTE_WRAP4:  wrap_mask = MASK4;
            BTE_WRAP8:  wrap_mask = MASK8;
            BTE_WRAP16: wrap_mask = MASK16;
            default:    wrap_mask = '1;
        endcase
        case (cti)
            CTI_INCR:  next_adr = (adr & ~wrap_mask) | (inc & wrap_mask);
            CTI_CONST: next_adr = adr;
            default:   next_adr = adr;
        endcase
    end

endmodule

// File: rtl/wb_slave_bfm.sv
// Wishbone B3 slave front-end: turns bus cycles into per-beat back-end requests.
module wb_slave_bfm
    import wb_bfm_pkg::*;
#(
    parameter int aw = 32,
    parameter int dw = 32
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    input  logic [aw-1:0]   wb_adr_i,
    input  logic [dw-1:0]   wb_dat_i,
    input  logic [dw/8-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic [2:0]      wb_cti_i,
    input  logic [1:0]      wb_bte_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    output logic [dw-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic            wb_rty_o,
    output logic            req_valid,
    output logic            req_we,
    output logic [aw-1:0]   req_adr,
    output logic [dw-1:0]   req_dat,
    output logic [dw/8-1:0] req_sel,
    output logic            req_burst,
    output logic            req_last,
    input  logic            rsp_valid,
    input  logic            rsp_err,
    input  logic [dw-1:0]   rsp_dat
);

    state_t        state;
    logic          burst;
    logic          done;
    logic [aw-1:0] adr;
    logic [aw-1:0] adr_next;

    wb_next_adr #(
        .aw(aw),
        .dw(dw)
    ) u_next_adr (
        .adr     (adr),
        .cti     (wb_cti_i),
        .bte     (wb_bte_i),
        .next_adr(adr_next)
    );

    // Write payload comes straight from the bus; the address is always the internal one
    assign req_valid = (state == ST_WAIT);
    assign req_we    = wb_we_i;
    assign req_dat   = wb_dat_i;
    assign req_sel   = wb_sel_i;
    assign req_adr   = adr;
    assign req_burst = burst;
    assign req_last  = is_last(burst, wb_cti_i);
    assign wb_rty_o  = 1'b0;

    // Beat sequencing: latch cycle start, wait for the back-end, pulse ack/err for one cycle
    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            state    <= ST_IDLE;
            burst    <= CLASSIC_CYCLE;
            done     <= 1'b0;
            adr      <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        burst <= (wb_cti_i != CTI_CLASSIC) ? BURST_CYCLE : CLASSIC_CYCLE;
                        adr   <= wb_adr_i;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A master abandoning the cycle wins over a same-cycle response
                    if (!wb_cyc_i) begin
                        state <= ST_IDLE;
                    end else if (rsp_valid) begin
                        wb_ack_o <= !rsp_err;
                        wb_err_o <= rsp_err;
                        if (!wb_we_i) begin
                            wb_dat_o <= rsp_dat;
                        end
                        done  <= req_last || rsp_err;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Bus still shows this beat's cti/bte here, so the next address uses them
                    if (done) begin
                        state <= ST_IDLE;
                    end else begin
                        adr   <= adr_next;
                        state <= ST_WAIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_slave_bfm.sv
// Self-checking bench for wb_slave_bfm: bench acts as Wishbone master and back-end.
module tb_wb_slave_bfm;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b0;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i = 1'b0;
    logic [2:0]  wb_cti_i = '0;
    logic [1:0]  wb_bte_i = '0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o, wb_rty_o;
    logic        req_valid, req_we, req_burst, req_last;
    logic [31:0] req_adr, req_dat;
    logic [3:0]  req_sel;
    logic        rsp_valid = 1'b0;
    logic        rsp_err = 1'b0;
    logic [31:0] rsp_dat = '0;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        last;
        logic        burst;
    } req_t;

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] dat;
    } rsp_t;

    req_t exp_req_q[$];
    rsp_t exp_rsp_q[$];
    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] model_dat = '0;

    wb_slave_bfm #(.aw(32), .dw(32)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
        .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
        .req_valid(req_valid), .req_we(req_we), .req_adr(req_adr), .req_dat(req_dat),
        .req_sel(req_sel), .req_burst(req_burst), .req_last(req_last),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_dat(rsp_dat)
    );

    always #5 wb_clk = ~wb_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, want finish before timeout");
        $fatal(1, "watchdog expired");
    end

    // One beat: drive master signals, act as back-end after 'delay' extra WAIT cycles
    task automatic beat(input logic [31:0] bus_adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte,
                        input int delay, input logic rerr, input logic [31:0] rdat,
                        input logic [31:0] exp_adr, input logic exp_burst, input int exp_lat);
        req_t r;
        rsp_t s;
        int waits;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = bus_adr; wb_we_i = we;
        wb_dat_i = dat; wb_sel_i = sel; wb_cti_i = cti; wb_bte_i = bte;
        r.adr = exp_adr; r.we = we; r.sel = sel; r.dat = dat; r.burst = exp_burst;
        r.last = (exp_burst == 1'b0) || (cti == 3'b111);
        exp_req_q.push_back(r);
        if (!we) model_dat = rdat;
        s.ack = !rerr; s.err = rerr; s.dat = model_dat;
        exp_rsp_q.push_back(s);
        waits = 0;
        do begin
            @(negedge wb_clk);
            waits++;
        end while (!req_valid && waits < 10);
        n_tests++;
        if (waits !== exp_lat || req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL req_latency: got %0d cycles (valid=%b), want %0d", waits, req_valid, exp_lat);
        end
        r = exp_req_q.pop_front();
        n_tests++;
        if (req_adr !== r.adr) begin n_fail++; $display("FAIL req_adr: got %h want %h", req_adr, r.adr); end
        n_tests++;
        if (req_we !== r.we) begin n_fail++; $display("FAIL req_we: got %b want %b", req_we, r.we); end
        n_tests++;
        if (req_sel !== r.sel) begin n_fail++; $display("FAIL req_sel: got %b want %b", req_sel, r.sel); end
        n_tests++;
        if (req_dat !== r.dat) begin n_fail++; $display("FAIL req_dat: got %h want %h", req_dat, r.dat); end
        n_tests++;
        if (req_last !== r.last) begin n_fail++; $display("FAIL req_last: got %b want %b", req_last, r.last); end
        n_tests++;
        if (req_burst !== r.burst) begin n_fail++; $display("FAIL req_burst: got %b want %b", req_burst, r.burst); end
        for (int i = 0; i < delay; i++) begin
            @(negedge wb_clk);
            n_tests++;
            if (req_valid !== 1'b1 || wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_hold: got valid=%b ack=%b err=%b want 1 0 0", req_valid, wb_ack_o, wb_err_o);
            end
        end
        rsp_valid = 1'b1; rsp_err = rerr; rsp_dat = rdat;
        @(posedge wb_clk);
        #1;
        rsp_valid = 1'b0; rsp_err = 1'b0; rsp_dat = $urandom;
        @(negedge wb_clk);
        s = exp_rsp_q.pop_front();
        n_tests++;
        if (wb_ack_o !== s.ack) begin n_fail++; $display("FAIL resp_ack: got %b want %b", wb_ack_o, s.ack); end
        n_tests++;
        if (wb_err_o !== s.err) begin n_fail++; $display("FAIL resp_err: got %b want %b", wb_err_o, s.err); end
        n_tests++;
        if (wb_dat_o !== s.dat) begin n_fail++; $display("FAIL resp_dat: got %h want %h", wb_dat_o, s.dat); end
        n_tests++;
        if (wb_rty_o !== 1'b0 || req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_cycle: got rty=%b valid=%b want 0 0", wb_rty_o, req_valid);
        end
        @(posedge wb_clk);
        #1;
    endtask

    // Master ends the cycle; the slave must be idle with no response pulse
    task automatic end_cycle();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_cti_i = '0; wb_bte_i = '0;
        @(negedge wb_clk);
        n_tests++;
        if (req_valid !== 1'b0 || wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after: got valid=%b ack=%b err=%b want 0 0 0", req_valid, wb_ack_o, wb_err_o);
        end
        @(posedge wb_clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge wb_clk);
        @(negedge wb_clk);
        n_tests++;
        if (wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", wb_ack_o); end
        n_tests++;
        if (wb_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", wb_err_o); end
        n_tests++;
        if (wb_rty_o !== 1'b0) begin n_fail++; $display("FAIL rst_rty: got %b want 0", wb_rty_o); end
        n_tests++;
        if (wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL rst_dat: got %h want 0", wb_dat_o); end
        n_tests++;
        if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", req_valid); end
        n_tests++;
        if (req_adr !== 32'h0) begin n_fail++; $display("FAIL rst_adr: got %h want 0", req_adr); end
        @(posedge wb_clk);
        #1;
        wb_rst = 1'b1;
        rsp_valid = 1'b1; rsp_dat = 32'hCAFEF00D;
        repeat (2) begin
            @(negedge wb_clk);
            n_tests++;
            if (wb_ack_o !== 1'b0 || req_valid !== 1'b0 || wb_dat_o !== 32'h0) begin
                n_fail++;
                $display("FAIL idle_rsp_ignored: got ack=%b valid=%b dat=%h want 0 0 0", wb_ack_o, req_valid, wb_dat_o);
            end
        end
        rsp_valid = 1'b0;
        @(posedge wb_clk);
        #1;
    endtask

    task automatic test_classic_write();
        beat(32'h10, 1'b1, 32'hDEADBEEF, 4'b0011, 3'b000, 2'b00, 0, 1'b0, 32'h0, 32'h10, 1'b0, 2);
        end_cycle();
    endtask

    task automatic test_classic_read();
        beat(32'h20, 1'b0, 32'h0, 4'hF, 3'b000, 2'b00, 3, 1'b0, 32'h12345678, 32'h20, 1'b0, 2);
        end_cycle();
    endtask

    task automatic test_incr_burst();
        logic [31:0] exp_a[4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
        logic [2:0]  ctis[4]  = '{3'b010, 3'b010, 3'b010, 3'b111};
        int          dly[4]   = '{0, 1, 0, 2};
        for (int i = 0; i < 4; i++) begin
            beat((i == 0) ? 32'h100 : 32'hFFFF_FF00, 1'b0, 32'h0, 4'hF, ctis[i], 2'b00, dly[i],
                 1'b0, 32'hA000_0000 + 32'(i), exp_a[i], 1'b1, (i == 0) ? 2 : 1);
        end
        end_cycle();
    endtask

    task automatic test_wrap4_burst();
        logic [31:0] exp_a[4] = '{32'h0C, 32'h00, 32'h04, 32'h08};
        logic [2:0]  ctis[4]  = '{3'b010, 3'b010, 3'b010, 3'b111};
        for (int i = 0; i < 4; i++) begin
            beat((i == 0) ? 32'h0C : 32'h7777_0000, 1'b1, 32'hB000_0000 + 32'(i), 4'b1100 ^ 4'(i),
                 ctis[i], 2'b01, (i == 0) ? 1 : 0, 1'b0, 32'h0, exp_a[i], 1'b1, (i == 0) ? 2 : 1);
        end
        end_cycle();
    endtask

    task automatic test_const_burst();
        logic [2:0] ctis[3] = '{3'b001, 3'b001, 3'b111};
        for (int i = 0; i < 3; i++) begin
            beat((i == 0) ? 32'h80 : 32'h0000_0F00, 1'b0, 32'h0, 4'hF, ctis[i], 2'b00, 0,
                 1'b0, 32'hC000_0000 + 32'(i), 32'h80, 1'b1, (i == 0) ? 2 : 1);
        end
        end_cycle();
    endtask

    task automatic test_error();
        beat(32'h200, 1'b0, 32'h0, 4'hF, 3'b010, 2'b00, 0, 1'b0, 32'h1111_1111, 32'h200, 1'b1, 2);
        beat(32'hFFFF_FF00, 1'b0, 32'h0, 4'hF, 3'b010, 2'b00, 1, 1'b1, 32'hBAD0_BAD0, 32'h204, 1'b1, 1);
        end_cycle();
    endtask

    task automatic test_abort_cyc();
        int waits;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 32'h50; wb_we_i = 1'b0;
        wb_sel_i = 4'hF; wb_cti_i = 3'b000; wb_bte_i = 2'b00;
        waits = 0;
        do begin
            @(negedge wb_clk);
            waits++;
        end while (!req_valid && waits < 10);
        n_tests++;
        if (req_valid !== 1'b1) begin n_fail++; $display("FAIL abort_start: got valid=%b want 1", req_valid); end
        @(posedge wb_clk);
        #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge wb_clk);
        rsp_valid = 1'b1; rsp_err = 1'b0; rsp_dat = 32'h5555_AAAA;
        @(negedge wb_clk);
        n_tests++;
        if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_noack: got ack=%b err=%b valid=%b want 0 0 0", wb_ack_o, wb_err_o, req_valid);
        end
        n_tests++;
        if (wb_dat_o !== model_dat) begin n_fail++; $display("FAIL abort_dat: got %h want %h", wb_dat_o, model_dat); end
        rsp_valid = 1'b0;
        @(posedge wb_clk);
        #1;
    endtask

    task automatic test_back_to_back();
        beat(32'h40, 1'b1, 32'h0BAD_CAFE, 4'b0101, 3'b000, 2'b00, 0, 1'b0, 32'h0, 32'h40, 1'b0, 2);
        beat(32'h44, 1'b0, 32'h0, 4'hF, 3'b000, 2'b00, 1, 1'b0, 32'h8765_4321, 32'h44, 1'b0, 2);
        end_cycle();
    endtask

    task automatic test_reset_mid_burst();
        beat(32'h300, 1'b0, 32'h0, 4'hF, 3'b010, 2'b00, 0, 1'b0, 32'hC0FF_EE01, 32'h300, 1'b1, 2);
        wb_adr_i = 32'hFFFF_FF00; wb_cti_i = 3'b010;
        @(negedge wb_clk);
        n_tests++;
        if (req_valid !== 1'b1 || req_adr !== 32'h304) begin
            n_fail++;
            $display("FAIL midrst_beat2: got valid=%b adr=%h want 1 00000304", req_valid, req_adr);
        end
        wb_rst = 1'b0; rsp_valid = 1'b1; rsp_dat = 32'h9999_9999;
        @(negedge wb_clk);
        n_tests++;
        if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || wb_rty_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_resp: got ack=%b err=%b rty=%b want 0 0 0", wb_ack_o, wb_err_o, wb_rty_o);
        end
        n_tests++;
        if (wb_dat_o !== 32'h0 || req_valid !== 1'b0 || req_adr !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_state: got dat=%h valid=%b adr=%h want 0 0 0", wb_dat_o, req_valid, req_adr);
        end
        model_dat = '0;
        rsp_valid = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = '0;
        @(posedge wb_clk);
        #1;
        wb_rst = 1'b1;
        end_cycle();
    endtask

    initial begin
        test_reset();
        test_classic_write();
        test_classic_read();
        test_incr_burst();
        test_wrap4_burst();
        test_const_burst();
        test_error();
        test_abort_cyc();
        test_back_to_back();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
